// File: rtl/fold_bus_collector.sv
// Rebuilds folded A-channel transactions (header, opcode, BEATS data beats) into
// {opcode, data} words, queues them in a small FIFO and flags protocol/overflow faults.
//
// state | meaning
// IDLE  | no transaction in assembly; beats on the bus are ignored
// ASM   | collecting beats of the current transaction, expecting beat cnt_q
module fold_bus_collector #(
   parameter int DATA_W     = 8,
   parameter int BEATS      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       a_valid,
   input  logic [3:0]                 a_opcode,
   input  logic [$clog2(BEATS)-1:0]   a_beat,
   input  logic [DATA_W-1:0]          a_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 out_opcode,
   output logic [DATA_W*BEATS-1:0]    out_data,
   output logic                       err_proto,
   output logic                       err_ovf,
   output logic [CNT_W-1:0]           drop_cnt,
   input  logic                       err_clr
);

   localparam int BW   = $clog2(BEATS);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam int DW   = DATA_W * BEATS;
   localparam int WW   = 4 + DW;
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   typedef enum logic {IDLE = 1'b0, ASM = 1'b1} state_t;

   state_t                         state_q, state_d;
   logic                           v_d1_q, v_d2_q;
   logic [3:0]                     op_hold_q;
   logic [3:0]                     asm_op_q, asm_op_d;
   logic [BW-1:0]                  cnt_q, cnt_d;
   logic [BEATS-1:0][DATA_W-1:0]   slot_q, slot_d;

   logic                           push;
   logic [WW-1:0]                  push_word;
   logic                           proto_set;
   logic                           active;
   logic                           hand_off;
   logic [BW-1:0]                  cur_cnt;
   logic [3:0]                     cur_op;

   logic [WW-1:0]                  mem_q [FIFO_DEPTH];
   logic [AW-1:0]                  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]                  count_q, count_d;
   logic                           full;
   logic                           pop;
   logic                           push_ok;
   logic                           drop;

   logic                           err_proto_q, err_ovf_q;
   logic [CNT_W-1:0]               drop_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_d1_q    <= 1'b0;
         v_d2_q    <= 1'b0;
         op_hold_q <= '0;
         asm_op_q  <= '0;
         cnt_q     <= '0;
         slot_q    <= '0;
         state_q   <= IDLE;
      end else begin
         v_d1_q  <= a_valid;
         v_d2_q  <= v_d1_q;
         if (v_d1_q) begin
            op_hold_q <= a_opcode;
         end
         asm_op_q <= asm_op_d;
         cnt_q    <= cnt_d;
         slot_q   <= slot_d;
         state_q  <= state_d;
      end
   end

   // A header reaching v_d2 coincides with its beat 0, so the new transaction is
   // evaluated in that same cycle with cnt=0 and the freshly held opcode. The one
   // exception is a header landing on the final beat of the running transaction:
   // that beat still belongs to the old transaction and the new one starts next cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      asm_op_d  = asm_op_q;
      slot_d    = slot_q;
      push      = 1'b0;
      proto_set = 1'b0;
      active    = 1'b0;
      cur_cnt   = cnt_q;
      cur_op    = asm_op_q;
      hand_off  = v_d2_q && (state_q == ASM) && (cnt_q == LAST);

      if (v_d2_q && !hand_off) begin
         if (state_q == ASM) begin
            proto_set = 1'b1;
         end
         active   = 1'b1;
         cur_cnt  = '0;
         cur_op   = op_hold_q;
         state_d  = ASM;
         asm_op_d = op_hold_q;
         cnt_d    = '0;
      end else if (state_q == ASM) begin
         active = 1'b1;
      end

      if (active) begin
         if (a_beat == cur_cnt) begin
            slot_d[cur_cnt] = a_data;
            if (cur_cnt == LAST) begin
               push    = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cur_cnt + BW'(1);
            end
         end else begin
            proto_set = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
         end
         if (hand_off) begin
            state_d  = ASM;
            cnt_d    = '0;
            asm_op_d = op_hold_q;
         end
      end

      push_word = {cur_op, slot_d};
   end

   assign out_valid = (count_q != '0);
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign pop       = out_valid && out_ready;
   assign push_ok   = push && (!full || pop);
   assign drop      = push && full && !pop;
   assign count_d   = count_q + CW'(push_ok) - CW'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is only visible while count is non-zero.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_word;
      end
   end

   assign out_opcode = out_valid ? mem_q[rd_ptr_q][WW-1 -: 4] : 4'h0;
   assign out_data   = out_valid ? mem_q[rd_ptr_q][DW-1:0]    : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_proto_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         drop_q      <= '0;
      end else if (err_clr) begin
         err_proto_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         drop_q      <= '0;
      end else begin
         if (proto_set) begin
            err_proto_q <= 1'b1;
         end
         if (drop) begin
            err_ovf_q <= 1'b1;
            if (drop_q != '1) begin
               drop_q <= drop_q + CNT_W'(1);
            end
         end
      end
   end

   assign err_proto = err_proto_q;
   assign err_ovf   = err_ovf_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fold_bus_collector.sv
// Self-checking bench for fold_bus_collector: directed table vectors, corner
// sequences, and randomized traffic against a transaction-level FIFO model.
module tb_fold_bus_collector;

   localparam int MAXC = 512;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 1'b0;
   logic [3:0]  a_opcode = '0;
   logic [1:0]  a_beat = '0;
   logic [7:0]  a_data = '0;
   logic        out_ready = 1'b0;
   logic        err_clr = 1'b0;
   logic        out_valid;
   logic [3:0]  out_opcode;
   logic [31:0] out_data;
   logic        err_proto;
   logic        err_ovf;
   logic [7:0]  drop_cnt;

   fold_bus_collector dut (
      .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_opcode(a_opcode),
      .a_beat(a_beat), .a_data(a_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_data(out_data), .err_proto(err_proto),
      .err_ovf(err_ovf), .drop_cnt(drop_cnt), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // per-cycle schedule of inputs
   logic        s_v [MAXC];
   logic [3:0]  s_op [MAXC];
   logic [1:0]  s_bt [MAXC];
   logic [7:0]  s_dt [MAXC];
   logic        s_rdy [MAXC];
   logic        s_clr [MAXC];
   logic        s_rst [MAXC];
   // per-cycle recorded outputs
   logic        r_v [MAXC];
   logic [3:0]  r_op [MAXC];
   logic [31:0] r_dt [MAXC];
   logic        r_ep [MAXC];
   logic        r_eo [MAXC];
   logic [7:0]  r_dc [MAXC];
   // model: words expected to complete at the end of a given cycle
   logic        m_push [MAXC];
   logic [35:0] m_word [MAXC];

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  b0, b1, b2, b3;
      logic [3:0]  exp_op;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_sched();
      for (int c = 0; c < MAXC; c++) begin
         s_v[c] = 1'b0; s_op[c] = '0; s_bt[c] = '0; s_dt[c] = '0;
         s_rdy[c] = 1'b1; s_clr[c] = 1'b0; s_rst[c] = 1'b1;
         m_push[c] = 1'b0; m_word[c] = '0;
      end
   endtask

   task automatic add_txn(input int t, input logic [3:0] op, input logic [31:0] d);
      s_v[t] = 1'b1;
      s_op[t+1] = op;
      for (int k = 0; k < 4; k++) begin
         s_bt[t+2+k] = 2'(k);
         s_dt[t+2+k] = d[k*8 +: 8];
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst_n = s_rst[i]; a_valid = s_v[i]; a_opcode = s_op[i];
         a_beat = s_bt[i]; a_data = s_dt[i]; out_ready = s_rdy[i]; err_clr = s_clr[i];
         @(negedge clk);
         r_v[i] = out_valid; r_op[i] = out_opcode; r_dt[i] = out_data;
         r_ep[i] = err_proto; r_eo[i] = err_ovf; r_dc[i] = drop_cnt;
      end
   endtask

   // Drains the FIFO and clears sticky flags between scenarios.
   task automatic settle();
      clear_sched();
      s_clr[2] = 1'b1;
      run(8);
   endtask

   initial begin
      int t;
      int n;
      int vcount;
      logic [35:0] q[$];
      logic        m_ovf;
      logic [7:0]  m_drop;
      logic        popped;

      vecs[0] = '{op: 4'hA, b0: 8'h0E, b1: 8'h1F, b2: 8'h2A, b3: 8'h3B, exp_op: 4'hA, exp_data: 32'h3B2A1F0E};
      vecs[1] = '{op: 4'h0, b0: 8'hFF, b1: 8'h00, b2: 8'hFF, b3: 8'h00, exp_op: 4'h0, exp_data: 32'h00FF00FF};
      vecs[2] = '{op: 4'hF, b0: 8'h78, b1: 8'h56, b2: 8'h34, b3: 8'h12, exp_op: 4'hF, exp_data: 32'h12345678};
      vecs[3] = '{op: 4'h5, b0: 8'h01, b1: 8'h80, b2: 8'hC3, b3: 8'h7E, exp_op: 4'h5, exp_data: 32'h7EC38001};

      // reset state
      clear_sched();
      s_rst[0] = 1'b0; s_rst[1] = 1'b0;
      s_v[0] = 1'b1; s_v[1] = 1'b1; s_bt[1] = 2'd0;
      run(4);
      chk("rst_valid", 64'(r_v[1]), 64'd0);
      chk("rst_data", {28'd0, r_op[1], r_dt[1]}, 64'd0);
      chk("rst_flags", {54'd0, r_ep[1], r_eo[1], r_dc[1]}, 64'd0);
      settle();

      // single-transaction table, latency 6, held until ready
      for (int v = 0; v < 4; v++) begin
         clear_sched();
         add_txn(0, vecs[v].op, {vecs[v].b3, vecs[v].b2, vecs[v].b1, vecs[v].b0});
         for (int c = 0; c < 7; c++) s_rdy[c] = 1'b0;
         run(12);
         chk($sformatf("v%0d_valid5", v), 64'(r_v[5]), 64'd0);
         chk($sformatf("v%0d_valid6", v), 64'(r_v[6]), 64'd1);
         chk($sformatf("v%0d_op", v), 64'(r_op[6]), 64'(vecs[v].exp_op));
         chk($sformatf("v%0d_data", v), 64'(r_dt[6]), 64'(vecs[v].exp_data));
         chk($sformatf("v%0d_popped", v), 64'(r_v[8]), 64'd0);
         chk($sformatf("v%0d_noerr", v), 64'(r_ep[11]), 64'd0);
         settle();
      end

      // back-to-back
      clear_sched();
      add_txn(0, 4'h1, 32'hAABBCCDD);
      add_txn(4, 4'h2, 32'h11223344);
      run(14);
      chk("b2b_v6", 64'(r_v[6]), 64'd1);
      chk("b2b_t0", {28'd0, r_op[6], r_dt[6]}, {28'd0, 4'h1, 32'hAABBCCDD});
      chk("b2b_v7", 64'(r_v[7]), 64'd0);
      chk("b2b_v9", 64'(r_v[9]), 64'd0);
      chk("b2b_v10", 64'(r_v[10]), 64'd1);
      chk("b2b_t1", {28'd0, r_op[10], r_dt[10]}, {28'd0, 4'h2, 32'h11223344});
      chk("b2b_noerr", 64'(r_ep[13]), 64'd0);
      settle();

      // beat mismatch, then a clean transaction
      clear_sched();
      add_txn(0, 4'h3, 32'h44332211);
      s_bt[4] = 2'd3;
      s_bt[5] = 2'd3;
      add_txn(10, 4'h9, 32'hCAFEF00D);
      for (int c = 0; c < 16; c++) s_rdy[c] = 1'b0;
      run(18);
      chk("mis_err4", 64'(r_ep[4]), 64'd0);
      chk("mis_err5", 64'(r_ep[5]), 64'd1);
      vcount = 0;
      for (int c = 0; c < 16; c++) vcount += int'(r_v[c]);
      chk("mis_nopush", 64'(vcount), 64'd0);
      chk("mis_clean_v", 64'(r_v[16]), 64'd1);
      chk("mis_clean", {28'd0, r_op[16], r_dt[16]}, {28'd0, 4'h9, 32'hCAFEF00D});
      settle();

      // overflow: five transactions into a four-deep FIFO with no consumer
      clear_sched();
      for (int k = 0; k < 5; k++) add_txn(4*k, 4'(k+1), 32'h01010101 * (k+1));
      for (int c = 0; c < 24; c++) s_rdy[c] = 1'b0;
      s_clr[30] = 1'b1;
      run(33);
      chk("ovf_pre", {55'd0, r_eo[21], r_dc[21]}, 64'd0);
      chk("ovf_flag", 64'(r_eo[22]), 64'd1);
      chk("ovf_cnt", 64'(r_dc[22]), 64'd1);
      for (int k = 0; k < 4; k++)
         chk($sformatf("ovf_drain%0d", k), {27'd0, r_v[24+k], r_op[24+k], r_dt[24+k]},
             {27'd0, 1'b1, 4'(k+1), 32'h01010101 * (k+1)});
      chk("ovf_empty", 64'(r_v[28]), 64'd0);
      chk("ovf_sticky", 64'(r_eo[30]), 64'd1);
      chk("ovf_clr", {55'd0, r_eo[31], r_dc[31]}, 64'd0);
      settle();

      // early header aborts the running transaction
      clear_sched();
      add_txn(0, 4'h3, 32'hDEADBEEF);
      add_txn(2, 4'h4, 32'h0BADC0DE);
      for (int c = 0; c < 9; c++) s_rdy[c] = 1'b0;
      run(12);
      chk("early_err", {62'd0, r_ep[4], r_ep[5]}, 64'd1);
      chk("early_v7", 64'(r_v[7]), 64'd0);
      chk("early_v8", 64'(r_v[8]), 64'd1);
      chk("early_t1", {28'd0, r_op[8], r_dt[8]}, {28'd0, 4'h4, 32'h0BADC0DE});
      settle();

      // reset in the middle of a transaction
      clear_sched();
      add_txn(0, 4'h5, 32'h55555555);
      add_txn(10, 4'h8, 32'h88888888);
      s_bt[14] = 2'd0;
      add_txn(20, 4'h6, 32'h66666666);
      add_txn(30, 4'h7, 32'h77777777);
      s_rst[23] = 1'b0; s_rst[24] = 1'b0;
      for (int c = 0; c < 37; c++) s_rdy[c] = 1'b0;
      run(40);
      chk("rst_pre", {62'd0, r_v[22], r_ep[22]}, 64'd3);
      chk("rst_outs", {20'd0, r_v[23], r_op[23], r_dt[23], r_ep[23], r_eo[23], r_dc[23]}, 64'd0);
      vcount = 0;
      for (int c = 23; c < 36; c++) vcount += int'(r_v[c]);
      chk("rst_nopartial", 64'(vcount), 64'd0);
      chk("rst_next", {27'd0, r_v[36], r_op[36], r_dt[36]}, {27'd0, 1'b1, 4'h7, 32'h77777777});
      settle();

      // randomized traffic against a transaction-level model
      clear_sched();
      t = 2;
      for (int k = 0; k < 45; k++) begin
         logic [3:0]  op;
         logic [31:0] d;
         op = 4'($urandom_range(0, 15));
         d  = $urandom;
         add_txn(t, op, d);
         m_push[t+5] = 1'b1;
         m_word[t+5] = {op, d};
         t += $urandom_range(4, 7);
      end
      n = t + 12;
      for (int c = 0; c < n; c++) begin
         s_rdy[c] = ($urandom_range(0, 99) < 45);
         s_clr[c] = ($urandom_range(0, 79) == 0);
      end
      for (int c = n - 8; c < n; c++) s_rdy[c] = 1'b1;
      run(n);
      q.delete();
      m_ovf = 1'b0;
      m_drop = '0;
      for (int c = 0; c < n; c++) begin
         chk($sformatf("rnd_valid@%0d", c), 64'(r_v[c]), 64'(q.size() != 0));
         if (q.size() != 0)
            chk($sformatf("rnd_word@%0d", c), {28'd0, r_op[c], r_dt[c]}, {28'd0, q[0]});
         chk($sformatf("rnd_flags@%0d", c), {54'd0, r_ep[c], r_eo[c], r_dc[c]},
             {54'd0, 1'b0, m_ovf, m_drop});
         popped = (q.size() != 0) && s_rdy[c];
         if (popped) void'(q.pop_front());
         if (m_push[c]) begin
            if (q.size() < 4) q.push_back(m_word[c]);
            else if (!s_clr[c]) begin
               m_ovf = 1'b1;
               if (m_drop != 8'hFF) m_drop++;
            end
         end
         if (s_clr[c]) begin
            m_ovf = 1'b0;
            m_drop = '0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
